fp_op_arbiter: RTL and testbench
================================

# fp_op_arbiter

Shares one pipelined floating-point operator core (add, sub, mult or div, valid/rdy result strobe, in-order results) among `C_REQ_NUM` requesters in the histogram-equalisation float datapath. Requests are round-robin arbitrated, one per cycle. Each accepted request's requester index is recorded in an in-order tag FIFO. Each core result is returned to the requester that issued it. Outstanding operations are bounded so the tag FIFO never overflows.

## Interface
Parameters:
- `C_DATA_WIDTH`, 32, float word width (IEEE-754 single).
- `C_REQ_NUM`, 4, number of requesters (2..8).
- `C_TAG_DEPTH`, 32, tag FIFO depth = maximum outstanding ops; must be ≥ core latency + 2 for full throughput.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  C_REQ_NUM  per-requester request strobe.
- `req_a`  in  C_REQ_NUM*C_DATA_WIDTH  operand A, requester i at bits [i*W +: W].
- `req_b`  in  C_REQ_NUM*C_DATA_WIDTH  operand B, same packing.
- `req_ready`  out  C_REQ_NUM  one-hot grant; request i is accepted when `req_valid[i] & req_ready[i]`.
- `core_a`, `core_b`  out  C_DATA_WIDTH  registered operands to the core.
- `core_valid`  out  1  registered issue strobe.
- `core_result`  in  C_DATA_WIDTH  core result.
- `core_rdy`  in  1  core result-valid strobe.
- `rsp_valid`  out  C_REQ_NUM  one-hot result strobe, registered.
- `rsp_data`  out  C_DATA_WIDTH  result word, shared by all requesters.
- `outstanding`  out  $clog2(C_TAG_DEPTH+1)  ops issued but not yet returned.
- `err_unexp`  out  1  sticky flag: `core_rdy` arrived with the tag FIFO empty.

## Operation
- **Grant:**
  - Combinational from `req_valid`, the round-robin pointer and `full`.
  - `full` = (`outstanding` == C_TAG_DEPTH).
  - When `full`, `req_ready` = 0.
  - Otherwise the lowest index ≥ (`ptr`+1) mod C_REQ_NUM with `req_valid` set is granted, wrapping.
  - `req_ready` is 0 when no request is valid.
- **Pointer:**
  - Register `ptr` updates to the granted index on every accept.
  - `ptr` is unchanged when nothing is accepted.
  - Reset value C_REQ_NUM-1, so requester 0 wins first.
- **Issue:**
  - On accept, `core_a`/`core_b` ← the granted operands and `core_valid` ← 1.
  - The granted index is pushed into the tag FIFO in the same cycle.
  - With no accept, `core_valid` ← 0 and the operands hold.
- **Return:**
  - On `core_rdy` with the FIFO non-empty, the head tag is popped.
  - Next cycle: `rsp_valid` ← one-hot(tag), `rsp_data` ← `core_result`.
- **Unexpected result:**
  - On `core_rdy` with the FIFO empty, the result is dropped and `rsp_valid` stays 0.
  - `err_unexp` ← 1 and stays set until reset.
- **Counter:**
  - `outstanding` +1 on accept only, −1 on a valid pop only.
  - Unchanged when an accept and a pop happen in the same cycle.
  - A same-cycle pop does not free a slot for a grant; `full` uses the registered count.
- The FIFO is a circular buffer with write/read pointers wrapping at C_TAG_DEPTH. Its occupancy equals `outstanding`.

## Timing
- Reset values: `req_ready` 0, `core_a`/`core_b` 0, `core_valid` 0, `rsp_valid` 0, `rsp_data` 0, `outstanding` 0, `err_unexp` 0, FIFO pointers 0, `ptr` C_REQ_NUM-1.
- Accept in cycle t gives `core_valid` high in t+1.
- `core_rdy` in cycle r gives `rsp_valid` in r+1.
- End-to-end latency = core latency + 2.
- Throughput: one issue per cycle while not `full`.
- Requesters must hold `req_valid`/operands until accepted.
- Reset mid-operation:
  - All state clears and in-flight tags are lost.
  - The core must share `reset`.
  - Any stale `core_rdy` after reset sets `err_unexp`.

## Configuration
- `FP_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority, lowest valid index wins.
  - `ptr` is not implemented.
- Undefined: round-robin as in Operation.
- All other behaviour is identical in both builds.

## Test plan
- All 4 requesters hold `req_valid`; core model has latency 10 and returns a+b.
  - Grants go 0,1,2,3,0,… on consecutive cycles.
  - Each `rsp_valid[i]` carries requester i's sum, in issue order, 12 cycles after its accept.
- Only requester 2 valid for 5 cycles.
  - 5 back-to-back grants to 2 and 5 responses to 2.
  - `ptr` stays at 2.
- C_TAG_DEPTH=4; core stalls (no `core_rdy`) while requester 0 streams.
  - Exactly 4 accepts, then `req_ready`=0 and `outstanding`=4.
  - One `core_rdy` gives `outstanding` 3, and the next cycle grants again.
- Accept and `core_rdy` in the same cycle: `outstanding` unchanged, and both FIFO pointers advance.
- `core_rdy` with `outstanding`=0: `err_unexp`=1 and no `rsp_valid`; `err_unexp` is held until `reset`.
- Reset asserted with 3 ops in flight:
  - Next cycle all outputs are at their reset values and `ptr`=C_REQ_NUM-1.
  - The first grant afterwards goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/fp_op_arbiter_if.sv
// fp_op_arbiter_if: requester, core and response signals of the shared FP operator arbiter.
interface fp_op_arbiter_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_REQ_NUM    = 4,
  parameter int C_TAG_DEPTH  = 32
);
  logic [C_REQ_NUM-1:0]              req_valid;
  logic [C_REQ_NUM-1:0]              req_ready;
  logic [C_REQ_NUM*C_DATA_WIDTH-1:0] req_a;
  logic [C_REQ_NUM*C_DATA_WIDTH-1:0] req_b;
  logic [C_DATA_WIDTH-1:0]           core_a;
  logic [C_DATA_WIDTH-1:0]           core_b;
  logic                              core_valid;
  logic [C_DATA_WIDTH-1:0]           core_result;
  logic                              core_rdy;
  logic [C_REQ_NUM-1:0]              rsp_valid;
  logic [C_DATA_WIDTH-1:0]           rsp_data;
  logic [$clog2(C_TAG_DEPTH+1)-1:0]  outstanding;
  logic                              err_unexp;
  modport master (
    output req_valid, req_a, req_b, core_result, core_rdy,
    input  req_ready, core_a, core_b, core_valid, rsp_valid, rsp_data, outstanding, err_unexp
  );
  modport slave (
    input  req_valid, req_a, req_b, core_result, core_rdy,
    output req_ready, core_a, core_b, core_valid, rsp_valid, rsp_data, outstanding, err_unexp
  );
endinterface

// File: rtl/fp_op_arbiter.sv
// fp_op_arbiter: shares one in-order pipelined FP core among requesters with tag-FIFO result routing.
// FP_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module fp_op_arbiter #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_REQ_NUM    = 4,
  parameter int C_TAG_DEPTH  = 32
) (
  input logic            clk,
  input logic            reset,
  fp_op_arbiter_if.slave bus
);
  localparam int PW = $clog2(C_REQ_NUM);
  localparam int TW = $clog2(C_TAG_DEPTH);
  localparam int OW = $clog2(C_TAG_DEPTH + 1);
  localparam logic [C_REQ_NUM-1:0] ONE = 1;
  logic [PW-1:0]           gnt_idx;
  logic                    gnt_any, full, empty, accept, pop;
  logic [PW-1:0]           tag_mem [C_TAG_DEPTH];
  logic [TW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]           outstanding_q, outstanding_d;
  logic [C_DATA_WIDTH-1:0] core_a_q, core_a_d, core_b_q, core_b_d, rsp_data_q, rsp_data_d;
  logic [C_REQ_NUM-1:0]    rsp_valid_q, rsp_valid_d;
  logic                    core_valid_q, core_valid_d, err_q, err_d;
`ifndef FP_ARB_FIXED_PRIO_EN
  logic [PW-1:0]           ptr_q, ptr_d;
`endif
  // Scan from farthest to nearest candidate so the nearest valid one wins.
  always_comb begin
    int j;
    j = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = C_REQ_NUM; k >= 1; k--) begin
`ifdef FP_ARB_FIXED_PRIO_EN
      j = k - 1;
`else
      j = (int'(ptr_q) + k) % C_REQ_NUM;
`endif
      if (bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end
  assign full   = outstanding_q == OW'(C_TAG_DEPTH);
  assign empty  = outstanding_q == '0;
  assign accept = gnt_any & ~full & ~reset;
  assign pop    = bus.core_rdy & ~empty;
  always_comb begin
    wr_d          = accept ? (wr_q == TW'(C_TAG_DEPTH - 1) ? '0 : wr_q + TW'(1)) : wr_q;
    rd_d          = pop ? (rd_q == TW'(C_TAG_DEPTH - 1) ? '0 : rd_q + TW'(1)) : rd_q;
    outstanding_d = (accept & ~pop) ? outstanding_q + OW'(1) :
                    (pop & ~accept) ? outstanding_q - OW'(1) : outstanding_q;
    core_a_d      = accept ? bus.req_a[int'(gnt_idx)*C_DATA_WIDTH +: C_DATA_WIDTH] : core_a_q;
    core_b_d      = accept ? bus.req_b[int'(gnt_idx)*C_DATA_WIDTH +: C_DATA_WIDTH] : core_b_q;
    core_valid_d  = accept;
    rsp_valid_d   = pop ? ONE << tag_mem[rd_q] : '0;
    rsp_data_d    = pop ? bus.core_result : rsp_data_q;
    err_d         = err_q | (bus.core_rdy & empty);
`ifndef FP_ARB_FIXED_PRIO_EN
    ptr_d         = accept ? gnt_idx : ptr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q          <= '0;
      rd_q          <= '0;
      outstanding_q <= '0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      core_valid_q  <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      err_q         <= 1'b0;
`ifndef FP_ARB_FIXED_PRIO_EN
      ptr_q         <= PW'(C_REQ_NUM - 1);
`endif
    end else begin
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      outstanding_q <= outstanding_d;
      core_a_q      <= core_a_d;
      core_b_q      <= core_b_d;
      core_valid_q  <= core_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      err_q         <= err_d;
`ifndef FP_ARB_FIXED_PRIO_EN
      ptr_q         <= ptr_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_q] <= gnt_idx;
  end
  assign bus.req_ready   = accept ? ONE << gnt_idx : '0;
  assign bus.core_a      = core_a_q;
  assign bus.core_b      = core_b_q;
  assign bus.core_valid  = core_valid_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.outstanding = outstanding_q;
  assign bus.err_unexp   = err_q;
endmodule

// File: tb/tb_fp_op_arbiter.sv
// tb_fp_op_arbiter: directed checks of arbitration, tag routing, back-pressure, errors and reset.
module tb_fp_op_arbiter;
  localparam int L = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fp_op_arbiter_if #(.C_DATA_WIDTH(32), .C_REQ_NUM(4), .C_TAG_DEPTH(32)) bus0 ();
  fp_op_arbiter_if #(.C_DATA_WIDTH(32), .C_REQ_NUM(4), .C_TAG_DEPTH(4))  bus1 ();
  fp_op_arbiter #(.C_DATA_WIDTH(32), .C_REQ_NUM(4), .C_TAG_DEPTH(32)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  fp_op_arbiter #(.C_DATA_WIDTH(32), .C_REQ_NUM(4), .C_TAG_DEPTH(4))  dut1 (.clk(clk), .reset(reset), .bus(bus1));
  // Core model for dut0: fixed latency L, returns a+b.
  logic [L-1:0] pv;
  logic [31:0]  pd [L];
  always_ff @(posedge clk) begin
    if (reset) pv <= '0;
    else pv <= {pv[L-2:0], bus0.core_valid};
    pd[0] <= bus0.core_a + bus0.core_b;
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign bus0.core_rdy    = pv[L-1];
  assign bus0.core_result = pd[L-1];
  function automatic logic [31:0] op_a(int i); return 32'h100 * (i + 1); endfunction
  function automatic logic [31:0] op_b(int i); return 32'(i + 5); endfunction
  localparam int FV  [14] = '{1,1,1,1,1,1,1,1,2,2,0,0,0,0};
  localparam int FR  [14] = '{0,0,0,0,0,0,1,0,1,1,1,1,1,0};
  localparam int FER [14] = '{1,1,1,1,0,0,0,1,0,2,0,0,0,0};
  localparam int FEO [14] = '{0,1,2,3,4,4,4,3,4,3,3,2,1,0};
  localparam int FES [14] = '{0,0,0,0,0,0,0,1,0,1,1,1,1,2};

  task automatic test_reset();
    reset = 1'b1;
    bus0.req_valid = '1;
    bus1.req_valid = '1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (bus0.req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus0.req_ready); end
    checks++; if (bus0.core_valid !== 1'b0) begin failures++; $display("FAIL reset_core_valid got=%b exp=0", bus0.core_valid); end
    checks++; if (bus0.core_a !== 32'h0 || bus0.core_b !== 32'h0) begin failures++; $display("FAIL reset_core_ops got=%h/%h exp=0/0", bus0.core_a, bus0.core_b); end
    checks++; if (bus0.rsp_valid !== 4'b0 || bus0.rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp got=%b/%h exp=0000/0", bus0.rsp_valid, bus0.rsp_data); end
    checks++; if (bus0.outstanding !== 6'd0 || bus0.err_unexp !== 1'b0) begin failures++; $display("FAIL reset_cnt_err got=%0d/%b exp=0/0", bus0.outstanding, bus0.err_unexp); end
    reset = 1'b0;
    bus0.req_valid = '0;
    bus1.req_valid = '0;
  endtask

  task automatic test_round_robin();
    for (int n = 0; n < 22; n++) begin
      @(posedge clk); #1;
      bus0.req_valid = (n < 8) ? 4'hF : 4'h0;
      #1;
      checks++; if (bus0.req_ready !== ((n < 8) ? 4'b1 << (n % 4) : 4'b0)) begin failures++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, bus0.req_ready, (n < 8) ? 4'b1 << (n % 4) : 4'b0); end
      if (n >= 1 && n <= 8) begin
        checks++; if (bus0.core_valid !== 1'b1 || bus0.core_a !== op_a((n - 1) % 4)) begin failures++; $display("FAIL rr_issue n=%0d got=%b/%h exp=1/%h", n, bus0.core_valid, bus0.core_a, op_a((n - 1) % 4)); end
      end
      if (n >= 12 && n < 20) begin
        checks++; if (bus0.rsp_valid !== 4'b1 << ((n - 12) % 4) || bus0.rsp_data !== op_a((n - 12) % 4) + op_b((n - 12) % 4)) begin failures++; $display("FAIL rr_rsp n=%0d got=%b/%h exp=%b/%h", n, bus0.rsp_valid, bus0.rsp_data, 4'b1 << ((n - 12) % 4), op_a((n - 12) % 4) + op_b((n - 12) % 4)); end
      end else begin
        checks++; if (bus0.rsp_valid !== 4'b0) begin failures++; $display("FAIL rr_rsp_idle n=%0d got=%b exp=0000", n, bus0.rsp_valid); end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 18; n++) begin
      @(posedge clk); #1;
      bus0.req_valid = (n < 5) ? 4'b0100 : 4'b0000;
      #1;
      checks++; if (bus0.req_ready !== ((n < 5) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL b2b_grant n=%0d got=%b", n, bus0.req_ready); end
      checks++; if (bus0.rsp_valid !== ((n >= 12 && n < 17) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL b2b_rsp n=%0d got=%b", n, bus0.rsp_valid); end
      if (n >= 12 && n < 17) begin
        checks++; if (bus0.rsp_data !== op_a(2) + op_b(2)) begin failures++; $display("FAIL b2b_data n=%0d got=%h exp=%h", n, bus0.rsp_data, op_a(2) + op_b(2)); end
      end
    end
    @(posedge clk); #1;
    bus0.req_valid = 4'hF;
    #1;
    checks++; if (bus0.req_ready !== 4'b1000) begin failures++; $display("FAIL ptr_after_b2b got=%b exp=1000", bus0.req_ready); end
    @(posedge clk); #1;
    bus0.req_valid = 4'h0;
    repeat (14) @(posedge clk);
    #2;
    checks++; if (bus0.outstanding !== 6'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", bus0.outstanding); end
  endtask

  task automatic test_full_and_same_cycle();
    bus1.req_a[31:0]  = 32'hA;
    bus1.req_a[63:32] = 32'hB;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      bus1.req_valid   = 4'(FV[c]);
      bus1.core_rdy    = FR[c][0];
      bus1.core_result = 32'h1111_0000 + 32'(c);
      #1;
      checks++; if (bus1.req_ready !== 4'(FER[c])) begin failures++; $display("FAIL full_grant c=%0d got=%b exp=%b", c, bus1.req_ready, 4'(FER[c])); end
      checks++; if (bus1.outstanding !== 3'(FEO[c])) begin failures++; $display("FAIL full_outstanding c=%0d got=%0d exp=%0d", c, bus1.outstanding, FEO[c]); end
      checks++; if (bus1.rsp_valid !== 4'(FES[c])) begin failures++; $display("FAIL full_rsp c=%0d got=%b exp=%b", c, bus1.rsp_valid, 4'(FES[c])); end
      if (FES[c] != 0) begin
        checks++; if (bus1.rsp_data !== 32'h1111_0000 + 32'(c - 1)) begin failures++; $display("FAIL full_data c=%0d got=%h exp=%h", c, bus1.rsp_data, 32'h1111_0000 + 32'(c - 1)); end
      end
    end
    checks++; if (bus1.err_unexp !== 1'b0) begin failures++; $display("FAIL full_err got=%b exp=0", bus1.err_unexp); end
  endtask

  task automatic test_unexpected();
    @(posedge clk); #1;
    bus1.core_rdy = 1'b1;
    bus1.core_result = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus1.core_rdy = 1'b0;
    #1;
    checks++; if (bus1.err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_err got=%b exp=1", bus1.err_unexp); end
    checks++; if (bus1.rsp_valid !== 4'b0 || bus1.rsp_data !== 32'h1111_000C) begin failures++; $display("FAIL unexp_rsp got=%b/%h exp=0000/1111000c", bus1.rsp_valid, bus1.rsp_data); end
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus1.err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_sticky got=%b exp=1", bus1.err_unexp); end
  endtask

  task automatic test_reset_midop();
    logic [3:0] er;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      reset = (n == 3 || n == 4);
      bus0.req_valid = (n <= 3 || n == 5) ? 4'hF : 4'h0;
      #1;
      er = (n < 3) ? 4'b1 << n : (n == 5) ? 4'b0001 : 4'b0000;
      checks++; if (bus0.req_ready !== er) begin failures++; $display("FAIL rst_grant n=%0d got=%b exp=%b", n, bus0.req_ready, er); end
      if (n == 2) begin
        checks++; if (bus0.outstanding !== 6'd2) begin failures++; $display("FAIL rst_inflight got=%0d exp=2", bus0.outstanding); end
      end
      if (n == 4) begin
        checks++; if (bus0.outstanding !== 6'd0 || bus0.core_valid !== 1'b0 || bus0.core_a !== 32'h0 || bus0.core_b !== 32'h0) begin failures++; $display("FAIL rst_state got=%0d/%b/%h/%h exp=0/0/0/0", bus0.outstanding, bus0.core_valid, bus0.core_a, bus0.core_b); end
        checks++; if (bus0.rsp_valid !== 4'b0 || bus0.rsp_data !== 32'h0 || bus1.err_unexp !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b/%h/%b exp=0000/0/0", bus0.rsp_valid, bus0.rsp_data, bus1.err_unexp); end
      end
      if (n >= 5) begin
        checks++; if (bus0.rsp_valid !== ((n == 17) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL rst_rsp n=%0d got=%b", n, bus0.rsp_valid); end
      end
      if (n == 17) begin
        checks++; if (bus0.rsp_data !== op_a(0) + op_b(0)) begin failures++; $display("FAIL rst_rsp_data got=%h exp=%h", bus0.rsp_data, op_a(0) + op_b(0)); end
      end
    end
    checks++; if (bus0.outstanding !== 6'd0 || bus0.err_unexp !== 1'b0) begin failures++; $display("FAIL rst_final got=%0d/%b exp=0/0", bus0.outstanding, bus0.err_unexp); end
  endtask

  initial begin
    bus0.req_valid = '0;
    bus1.req_valid = '0;
    bus1.req_a = '0;
    bus1.req_b = '0;
    bus1.core_rdy = 1'b0;
    bus1.core_result = '0;
    for (int i = 0; i < 4; i++) begin
      bus0.req_a[i*32 +: 32] = op_a(i);
      bus0.req_b[i*32 +: 32] = op_b(i);
    end
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_full_and_same_cycle();
    test_unexpected();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
